byte_word_packer: RTL

//   Upstream write-side stage of the 32x32 FIFO. Accepts a byte stream over a valid/ready

---
 rtl/byte_word_packer.sv | 109 ++++++++++
 1 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer: write-side stage in front of the 32x32 FIFO.
// Packs a valid/ready byte stream into 32-bit words. in_last flushes a partial
// word with PAD_BYTE in the unused lanes. A finished word is held until the
// FIFO is not full, then pushed with a single-cycle fifo_w_en.
//
// Optional feature macro: PACKER_BIG_ENDIAN_EN
//   undefined (default): first byte -> bits[7:0], padding fills high lanes
//   defined            : first byte -> bits[31:24], padding fills low lanes
//
// Handshake: a byte is transferred on a rising edge where in_valid & in_ready
// are both high; in_ready depends only on internal state, and the source holds
// in_byte/in_last stable until transferred.
module byte_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         WCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  input  logic              fifo_full,
  output logic              fifo_w_en,
  output logic [31:0]       fifo_data,
  output logic [WCNT_W-1:0] word_count,
  output logic              busy
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                accept;
  logic                finish;

  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  assign in_ready   = (state_q == ACCUM);
  assign accept     = in_valid & in_ready;
  // A word closes on the fourth lane or on an explicit end of message.
  assign finish     = (idx_q == 2'd3) | in_last;
  assign fifo_w_en  = (state_q == HOLD) & ~fifo_full;
  assign fifo_data  = word_q;
  assign word_count = wcnt_q;
  assign busy       = (state_q == HOLD) | (idx_q != 2'd0);

  // State, lane index, word and counter registers; reset discards held bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= 2'd0;
      word_q  <= 32'h0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state: lane fill and padding in ACCUM, push-and-clear in HOLD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
`ifdef PACKER_BIG_ENDIAN_EN
            if (k == int'(idx_q))
              word_d[8*(3-k) +: 8] = in_byte;
            else if (finish && (k > int'(idx_q)))
              word_d[8*(3-k) +: 8] = PAD_BYTE;
`else
            if (k == int'(idx_q))
              word_d[8*k +: 8] = in_byte;
            else if (finish && (k > int'(idx_q)))
              word_d[8*k +: 8] = PAD_BYTE;
`endif
          end
          if (finish) begin
            idx_d   = 2'd0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      HOLD: begin
        // Nothing moves while the FIFO is full; the word waits intact.
        if (!fifo_full) begin
          wcnt_d  = wcnt_q + WCNT_ONE;
          word_d  = 32'h0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

endmodule
